// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: column-scanned key matrix reader with 2-FF row sync and press/release debounce.
// Optional auto-repeat of key_valid while a key stays held: define KEYPAD_REPEAT_EN.
//
// state       | meaning
// SCAN        | drive column idx, wait SETTLE_CYCLES, then sample rows
// DEB_PRESS   | column frozen, rows must match the latched pattern DEBOUNCE_CYCLES times
// PRESSED     | key accepted and held; leaves when all rows read high
// DEB_RELEASE | rows must stay all-high DEBOUNCE_CYCLES times before scanning resumes
module keypad_matrix_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYCLES   = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ROWS-1:0]               rows_in,
  output logic [COLS-1:0]               columns_drive,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          key_valid,
  output logic                          key_held
);

  localparam int KEY_W = $clog2(ROWS*COLS);
  localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int T_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(COLS - 1);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

  state_t           state_q, state_d;
  logic [ROWS-1:0]  rows_meta_q, rows_meta_d;
  logic [ROWS-1:0]  rows_sync_q, rows_sync_d;
  logic [ROWS-1:0]  pattern_q, pattern_d;
  logic [COLS-1:0]  drive_q, drive_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             rows_idle;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

  function automatic logic [COLS-1:0] col_drive(input logic [IDX_W-1:0] i);
    return ~(COLS'(1) << i);
  endfunction

  // Lowest-index low row wins when several keys share the column.
  function automatic logic [KEY_W-1:0] code_of(input logic [IDX_W-1:0] col,
                                               input logic [ROWS-1:0] pat);
    int row;
    row = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!pat[r]) row = r;
    end
    return KEY_W'(int'(col) * ROWS + row);
  endfunction

  assign idx_next  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  assign rows_idle = (rows_sync_q == {ROWS{1'b1}});

  always_comb begin
    rows_meta_d = rows_in;
    rows_sync_d = rows_meta_q;
    state_d     = state_q;
    drive_d     = drive_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pattern_d   = pattern_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      SCAN: begin
        if (drive_q == {COLS{1'b1}}) begin
          drive_d = col_drive(idx_q);
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (rows_idle) begin
            idx_d   = idx_next;
            drive_d = col_drive(idx_next);
          end else begin
            pattern_d = rows_sync_q;
            state_d   = DEB_PRESS;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (rows_sync_q != pattern_q) begin
          state_d = SCAN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = PRESSED;
          cnt_d       = '0;
          key_code_d  = code_of(idx_q, pattern_q);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (rows_idle) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end
      end
      DEB_RELEASE: begin
        if (!rows_idle) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = SCAN;
          cnt_d      = '0;
          key_held_d = 1'b0;
          idx_d      = idx_next;
          drive_d    = col_drive(idx_next);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
`ifdef KEYPAD_REPEAT_EN
    // Counter is only meaningful inside PRESSED; every entry restarts the first delay.
    rep_cnt_d = '0;
    if (state_d == PRESSED && state_q != PRESSED) begin
      rep_cnt_d = REP_FIRST;
    end else if (state_d == PRESSED) begin
      if (rep_cnt_q == '0) begin
        key_valid_d = 1'b1;
        rep_cnt_d   = REP_NEXT;
      end else begin
        rep_cnt_d = rep_cnt_q - 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      rows_meta_q <= '1;
      rows_sync_q <= '1;
      pattern_q   <= '1;
      drive_q     <= '1;
      idx_q       <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rows_meta_q <= rows_meta_d;
      rows_sync_q <= rows_sync_d;
      pattern_q   <= pattern_d;
      drive_q     <= drive_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign columns_drive = drive_q;
  assign key_code      = key_code_q;
  assign key_valid     = key_valid_q;
  assign key_held      = key_held_q;

endmodule
